dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Shared data-memory arbiter for the dual-core processor. It sits between the two cores' load/store ports and the single 512-word data memory, and grants one access at a time with round-robin fairness. It holds off both cores while the serial loader owns memory (`Jen`). It also implements the inter-core `sync` barrier.

## Interface
Parameters:
- `DATA_W`, 32: data word width.
- `DEPTH`, 512: memory depth in words.
- `AW`, 9: word-address width, log2(`DEPTH`).

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `Jen`  in  1: loader owns memory; no new grants while high.
- `req0`, `req1`  in  1: core access request; held until `done`.
- `we0`, `we1`  in  1: 1 = sw (store), 0 = lw (load).
- `addr0`, `addr1`  in  32: byte address (rs + sext imm).
- `wdata0`, `wdata1`  in  `DATA_W`: store data.
- `rdata0`, `rdata1`  out  `DATA_W`: load result, valid while `done` is high.
- `done0`, `done1`  out  1: one-cycle completion pulse.
- `misalign0`, `misalign1`  out  1: pulses with `done` when `addr[1:0]` != 0.
- `mem_en`, `mem_we`  out  1: memory strobe and write enable.
- `mem_addr`  out  `AW`: word address = `addr[AW+1:2]` (upper bits dropped, wraps modulo `DEPTH`).
- `mem_wdata`  out  `DATA_W`: write data to memory.
- `mem_rdata`  in  `DATA_W`: registered memory read data, one-cycle latency.
- `sync_req0`, `sync_req1`  in  1: core is executing `sync`; held until `sync_done`.
- `sync_done0`, `sync_done1`  out  1: one-cycle barrier-release pulse.

## Operation
- The FSM has three states.
  - IDLE: samples the requests.
  - ACCESS: drives `mem_en`, plus `mem_we` for stores.
  - RESP: captures `mem_rdata` and pulses `done`.
- IDLE → ACCESS requires `Jen`=0 and at least one `req`. Otherwise the FSM stays in IDLE.
- ACCESS → RESP is unconditional. RESP → IDLE is unconditional.
- Arbitration:
  - Only one requester active: it is granted.
  - Both active: the core that was not `last_grant` wins.
  - `last_grant` updates on every grant.
- Requests are not sampled in RESP. A core may keep `req` high after `done` to issue a back-to-back access; it is re-sampled in the next IDLE.
- Addresses, write data and `we` are latched at grant. Later changes to the core inputs are ignored until `done`.
- Stores: `rdata` of the granted core holds its previous value.
- `misalign` pulses with `done` when the byte address is unaligned. The access still proceeds using the truncated word address.
- `Jen` rising while in ACCESS or RESP: the in-flight access completes normally, then the FSM parks in IDLE until `Jen` falls.
- All `mem_*` outputs are 0 in IDLE.

## Timing
- Reset values: all outputs 0, state = IDLE, `last_grant` = core 1 (so core 0 wins the first tie), barrier flags cleared.
- `req` high at edge E0 (state IDLE):
  - `mem_en` is high in the cycle after E0.
  - The memory reads/writes at E1.
  - `done` and `rdata` are high/valid in the cycle after E2.
  - `done` pulses exactly one cycle.
- Maximum throughput is one access per 3 cycles.
- With both cores saturating, grants alternate strictly.
- `rst` asserted mid-access: the FSM returns to IDLE immediately and no `done` is produced. A store interrupted in ACCESS may or may not be written.

## Configuration
- `SYNC_BARRIER_EN` defined:
  - A raised `sync_req` sets the arrived flag for that core.
  - When both flags are set, `sync_done0` and `sync_done1` pulse in the same cycle, one cycle after the later arrival. Both flags then clear.
  - Simultaneous arrival releases one cycle after the arrival.
  - The barrier is independent of memory arbitration.
- `SYNC_BARRIER_EN` undefined:
  - `sync_doneN` is `sync_reqN` registered and rising-edge detected.
  - `sync` is a one-cycle no-op per core with no inter-core wait.

## Structure
- Package `dmem_arb_pkg` holds:
  - the state enum (IDLE, ACCESS, RESP);
  - `DMEM_DEPTH` = 512 and `DMEM_AW` = 9;
  - the core-index typedef (1 bit).
- Sub-module `sync_barrier` contains the two arrival flags and the release logic, including both macro variants.
- The arbiter FSM stays in `dmem_arbiter`.

## Test plan
- Single load: preload mem[5]=0x1234, core 0 lw to address 20 → `mem_addr`=5, `done0` pulses 3 cycles after the request, `rdata0`=0x1234.
- Contention: `req0` and `req1` rise in the same cycle, both stores to address 20 (values 7 and 9) → core 0 granted first, then core 1; final mem[5]=9; `done0` precedes `done1` by 3 cycles.
- Fairness: both cores hold `req` for 12 cycles → grants alternate 0,1,0,1; no core is granted twice in a row.
- Loader: `Jen`=1 while `req0`=1 → no `mem_en` until `Jen` falls; access completes 3 cycles after the fall. Misaligned address 22 → `misalign0` pulses with `done0`, `mem_addr`=5.
- Barrier (`SYNC_BARRIER_EN` defined): `sync_req0` at cycle 10, `sync_req1` at cycle 25 → both `sync_done` pulse at cycle 26 and not before. Without the macro → `sync_done0` pulses at cycle 11.
- Reset mid-ACCESS: assert `rst` for 1 cycle → all outputs 0 immediately; next request behaves as first after reset, with core 0 winning the tie.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared types and constants for the data-memory arbiter
package dmem_arb_pkg;

    localparam int DMEM_DEPTH = 512;
    localparam int DMEM_AW    = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } arb_state_e;

    typedef logic core_idx_t;

    // Word accesses only: any nonzero byte offset is reported as misaligned
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return byte_off != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arbiter_sync_barrier.sv
// rtl/dmem_arbiter_sync_barrier.sv - inter-core sync barrier; SYNC_BARRIER_EN selects the two-core rendezvous
module sync_barrier (
    input  logic clk,
    input  logic rst,
    input  logic sync_req0,
    input  logic sync_req1,
    output logic sync_done0,
    output logic sync_done1
);

    logic req0_q;
    logic req1_q;
    logic rise0;
    logic rise1;

    // A core holds sync_req until released, so only the rising edge counts as arrival
    assign rise0 = sync_req0 & ~req0_q;
    assign rise1 = sync_req1 & ~req1_q;

    // Remember the previous request level for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req0_q <= 1'b0;
            req1_q <= 1'b0;
        end else begin
            req0_q <= sync_req0;
            req1_q <= sync_req1;
        end
    end

`ifdef SYNC_BARRIER_EN
    logic arr0_q;
    logic arr1_q;
    logic arr0_d;
    logic arr1_d;
    logic release_d;
    logic done_q;

    // Arrival flags accumulate; release once both cores are present (same edge counts)
    always_comb begin
        arr0_d    = arr0_q | rise0;
        arr1_d    = arr1_q | rise1;
        release_d = arr0_d & arr1_d;
    end

    // Release both cores in the same cycle and clear the flags for the next barrier
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arr0_q <= 1'b0;
            arr1_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= release_d;
            arr0_q <= arr0_d & ~release_d;
            arr1_q <= arr1_d & ~release_d;
        end
    end

    assign sync_done0 = done_q;
    assign sync_done1 = done_q;
`else
    logic done0_q;
    logic done1_q;

    // Without the barrier each sync retires on its own one cycle after it is raised
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
        end else begin
            done0_q <= rise0;
            done1_q <= rise1;
        end
    end

    assign sync_done0 = done0_q;
    assign sync_done1 = done1_q;
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - round-robin dual-core data-memory arbiter with loader hold-off; SYNC_BARRIER_EN enables the sync barrier
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = DMEM_DEPTH,
    parameter int AW     = DMEM_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              Jen,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [31:0]       addr0,
    input  logic [31:0]       addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              done0,
    output logic              done1,
    output logic              misalign0,
    output logic              misalign1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              sync_req0,
    input  logic              sync_req1,
    output logic              sync_done0,
    output logic              sync_done1
);

    localparam int WORD_W = $clog2(DEPTH);

    arb_state_e        state_q;
    core_idx_t         last_grant_q;
    core_idx_t         grant_q;
    logic              lat_we_q;
    logic              lat_mis_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [AW-1:0]     mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;
    logic              done0_q;
    logic              done1_q;
    logic              mis0_q;
    logic              mis1_q;

    core_idx_t         gnt_d;
    logic              start_d;
    logic              sel_we_d;
    logic              sel_mis_d;
    logic [WORD_W-1:0] word_addr_d;
    logic [DATA_W-1:0] sel_wdata_d;

    // Byte-address bits above the memory span are dropped so addresses wrap modulo DEPTH
    logic unused_addr_hi;
    assign unused_addr_hi = ^{addr0[31:AW+2], addr1[31:AW+2]};

    // Grant selection: a lone requester wins; on a tie the core not served last wins
    always_comb begin
        gnt_d = 1'b0;
        if (req0 && req1) begin
            gnt_d = ~last_grant_q;
        end else if (req1) begin
            gnt_d = 1'b1;
        end
        start_d     = !Jen && (req0 || req1);
        sel_we_d    = gnt_d ? we1 : we0;
        sel_wdata_d = gnt_d ? wdata1 : wdata0;
        word_addr_d = gnt_d ? addr1[AW+1:2] : addr0[AW+1:2];
        sel_mis_d   = is_misaligned(gnt_d ? addr1[1:0] : addr0[1:0]);
    end

    // Arbiter FSM: IDLE grants, ACCESS strobes memory, RESP returns data and pulses done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            lat_we_q     <= 1'b0;
            lat_mis_q    <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            mis0_q       <= 1'b0;
            mis1_q       <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            mis0_q  <= 1'b0;
            mis1_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_d) begin
                        state_q      <= ST_ACCESS;
                        grant_q      <= gnt_d;
                        last_grant_q <= gnt_d;
                        lat_we_q     <= sel_we_d;
                        lat_mis_q    <= sel_mis_d;
                        mem_en_q     <= 1'b1;
                        mem_we_q     <= sel_we_d;
                        mem_addr_q   <= word_addr_d;
                        mem_wdata_q  <= sel_wdata_d;
                    end
                end
                ST_ACCESS: begin
                    state_q     <= ST_RESP;
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    if (grant_q == 1'b0) begin
                        done0_q <= 1'b1;
                        mis0_q  <= lat_mis_q;
                        if (!lat_we_q) begin
                            rdata0_q <= mem_rdata;
                        end
                    end else begin
                        done1_q <= 1'b1;
                        mis1_q  <= lat_mis_q;
                        if (!lat_we_q) begin
                            rdata1_q <= mem_rdata;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;
    assign done0     = done0_q;
    assign done1     = done1_q;
    assign misalign0 = mis0_q;
    assign misalign1 = mis1_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    sync_barrier u_sync_barrier (
        .clk        (clk),
        .rst        (rst),
        .sync_req0  (sync_req0),
        .sync_req1  (sync_req1),
        .sync_done0 (sync_done0),
        .sync_done1 (sync_done1)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter; SYNC_BARRIER_EN selects barrier expectations
module tb_dmem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 9;
    localparam int DEPTH = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          Jen;
    logic          req0, req1, we0, we1;
    logic [31:0]   addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic [DW-1:0] rdata0, rdata1;
    logic          done0, done1, misalign0, misalign1;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          sync_req0, sync_req1, sync_done0, sync_done1;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] mem     [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_rd  [2];
    logic          model_last;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_W(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .Jen        (Jen),
        .req0       (req0),
        .req1       (req1),
        .we0        (we0),
        .we1        (we1),
        .addr0      (addr0),
        .addr1      (addr1),
        .wdata0     (wdata0),
        .wdata1     (wdata1),
        .rdata0     (rdata0),
        .rdata1     (rdata1),
        .done0      (done0),
        .done1      (done1),
        .misalign0  (misalign0),
        .misalign1  (misalign1),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .sync_req0  (sync_req0),
        .sync_req1  (sync_req1),
        .sync_done0 (sync_done0),
        .sync_done1 (sync_done1)
    );

    // Data memory with registered read
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {15'd0, rdata0, rdata1, done0, done1, misalign0, misalign1,
                mem_en, mem_we, mem_addr, mem_wdata, sync_done0, sync_done1};
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom();
        a[AW+1:2] = 9'($urandom_range(0, 15));
        if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    // One transaction round: predict service order and results from the arbitration rules,
    // then drive the cores and compare every response against the prediction.
    task automatic do_round(input logic r0, input logic r1, input logic w0, input logic w1,
                            input logic [31:0] a0, input logic [31:0] a1,
                            input logic [31:0] d0, input logic [31:0] d1,
                            input int jen_cyc, input logic scramble);
        logic        rw [2];
        logic [31:0] ra [2];
        logic [31:0] rdv [2];
        int          order [2];
        int          exp_cyc [2];
        logic        exp_mis [2];
        logic [31:0] exp_rdata [2];
        logic        pending [2];
        int          n_srv;
        int          seen_en;
        int          c;
        int          w;
        logic        dn, ms;
        logic [31:0] rd_o;

        rw[0] = w0; rw[1] = w1; ra[0] = a0; ra[1] = a1; rdv[0] = d0; rdv[1] = d1;
        order[0] = 0; order[1] = 1;
        if (r0 && r1) begin
            order[0] = model_last ? 0 : 1;
            order[1] = 1 - order[0];
            n_srv = 2;
        end else begin
            order[0] = r1 ? 1 : 0;
            n_srv = 1;
        end
        for (int k = 0; k < n_srv; k++) begin
            c = order[k];
            w = int'(ra[c][AW+1:2]);
            if (rw[c]) ref_mem[w] = rdv[c];
            else       exp_rd[c]  = ref_mem[w];
            exp_rdata[c] = exp_rd[c];
            exp_mis[c]   = (ra[c][1:0] != 2'b00);
            exp_cyc[c]   = jen_cyc + 3 * (k + 1);
            model_last   = c[0];
        end

        pending[0] = r0; pending[1] = r1;
        Jen  = (jen_cyc > 0);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        seen_en = 0;

        for (int t = 1; t <= 40 && (pending[0] || pending[1]); t++) begin
            tick();
            if (t <= jen_cyc) chk("jen_hold_mem_en", mem_en, 1'b0);
            if (t == jen_cyc) Jen = 1'b0;
            if (mem_en) begin
                if (seen_en < n_srv) begin
                    c = order[seen_en];
                    chk("mem_en_cycle", t, exp_cyc[c] - 2);
                    chk("mem_addr", mem_addr, ra[c][AW+1:2]);
                    chk("mem_we", mem_we, rw[c]);
                    if (rw[c]) chk("mem_wdata", mem_wdata, rdv[c]);
                    if (scramble) begin
                        if (c == 1) begin
                            addr1 = $urandom(); wdata1 = $urandom(); we1 = ~we1;
                        end else begin
                            addr0 = $urandom(); wdata0 = $urandom(); we0 = ~we0;
                        end
                    end
                    seen_en++;
                end else begin
                    chk("extra_grant", seen_en, n_srv - 1);
                end
            end
            if (done0 || done1) begin
                chk("done_exclusive", done0 & done1, 1'b0);
                chk("idle_mem_quiet", {mem_en, mem_we, mem_addr, mem_wdata}, '0);
            end
            for (int k = 0; k < 2; k++) begin
                dn   = (k == 1) ? done1 : done0;
                ms   = (k == 1) ? misalign1 : misalign0;
                rd_o = (k == 1) ? rdata1 : rdata0;
                if (dn) begin
                    chk("done_owner", pending[k], 1'b1);
                    if (pending[k]) begin
                        chk("done_cycle", t, exp_cyc[k]);
                        chk("rdata", rd_o, exp_rdata[k]);
                        chk("misalign", ms, exp_mis[k]);
                        pending[k] = 1'b0;
                        if (k == 1) req1 = 1'b0;
                        else        req0 = 1'b0;
                    end
                end else begin
                    chk("misalign_no_done", ms, 1'b0);
                end
            end
        end
        chk("round_complete", {pending[0], pending[1]}, 2'b00);
        Jen = 1'b0; req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic nxt;
        int   ngr;
        int   bad;
        logic sel_lo, sel_hi;
        int   sel;

        rst = 1'b1; Jen = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        sync_req0 = 1'b0; sync_req1 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i]     = $urandom();
            ref_mem[i] = mem[i];
        end
        model_last = 1'b1; exp_rd[0] = '0; exp_rd[1] = '0;
        tick(); tick();
        chk("reset_outputs", all_outs(), '0);
        rst = 1'b0;
        tick();
        chk("post_reset_idle", all_outs(), '0);

        // Single aligned load from byte 20 -> word 5
        mem[5] = 32'h1234; ref_mem[5] = 32'h1234;
        do_round(1'b1, 1'b0, 1'b0, 1'b0, 32'd20, 32'd0, 32'd0, 32'd0, 0, 1'b0);
        chk("single_load_value", rdata0, 32'h1234);

        // Loader holds memory for 4 cycles, then a misaligned load from byte 22
        do_round(1'b1, 1'b0, 1'b0, 1'b0, 32'd22, 32'd0, 32'd0, 32'd0, 4, 1'b0);

        // Loader takes memory while core 0 is in ACCESS; core 1 must wait for the release
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'd28;
        tick();
        chk("jen_mid_access_en", mem_en, 1'b1);
        Jen = 1'b1;
        tick();
        tick();
        chk("jen_mid_done0", done0, 1'b1);
        chk("jen_mid_rdata0", rdata0, ref_mem[7]);
        exp_rd[0] = ref_mem[7]; model_last = 1'b0; req0 = 1'b0;
        do_round(1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd36, 32'd0, 32'hCAFE_0001, 4, 1'b0);

        // Reset during ACCESS: outputs clear at once, no done, arbitration restarts
        req1 = 1'b1; we1 = 1'b1; addr1 = 32'd40; wdata1 = ref_mem[10];
        tick();
        chk("rst_pre_access", mem_en, 1'b1);
        rst = 1'b1;
        #1;
        chk("rst_async_outputs", all_outs(), '0);
        req1 = 1'b0;
        tick();
        rst = 1'b0;
        model_last = 1'b1; exp_rd[0] = '0; exp_rd[1] = '0;
        tick();
        chk("rst_no_done", all_outs(), '0);

        // Contention: both store to byte 20; core 0 first after reset
        do_round(1'b1, 1'b1, 1'b1, 1'b1, 32'd20, 32'd20, 32'd7, 32'd9, 0, 1'b0);
        chk("contention_mem5", mem[5], 32'd9);

        // Fairness: both cores hold requests for 12 cycles
        req0 = 1'b1; req1 = 1'b1; we0 = 1'b0; we1 = 1'b0; addr0 = 32'd12; addr1 = 32'd16;
        nxt = ~model_last; ngr = 0;
        for (int t = 1; t <= 12; t++) begin
            tick();
            if (done0 || done1) begin
                chk("fair_single", done0 & done1, 1'b0);
                chk("fair_order", done1, nxt);
                model_last = nxt; nxt = ~nxt; ngr++;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("fair_count", ngr, 4);
        exp_rd[0] = ref_mem[3]; exp_rd[1] = ref_mem[4];
        tick();

        // Randomized rounds against the reference model
        for (int r = 0; r < 40; r++) begin
            sel = $urandom_range(1, 3);
            sel_lo = sel[0]; sel_hi = sel[1];
            do_round(sel_lo, sel_hi, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     rand_addr(), rand_addr(), $urandom(), $urandom(),
                     ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                     1'($urandom_range(0, 1)));
        end

        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) bad++;
        chk("final_memory", bad, 0);

`ifdef SYNC_BARRIER_EN
        sync_req0 = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            chk("barrier_wait", {sync_done0, sync_done1}, 2'b00);
        end
        sync_req1 = 1'b1;
        tick();
        chk("barrier_release", {sync_done0, sync_done1}, 2'b11);
        sync_req0 = 1'b0; sync_req1 = 1'b0;
        tick();
        chk("barrier_pulse_len", {sync_done0, sync_done1}, 2'b00);
        sync_req0 = 1'b1; sync_req1 = 1'b1;
        tick();
        chk("barrier_simultaneous", {sync_done0, sync_done1}, 2'b11);
        sync_req0 = 1'b0; sync_req1 = 1'b0;
        tick();
        chk("barrier_clear", {sync_done0, sync_done1}, 2'b00);
`else
        sync_req0 = 1'b1;
        tick();
        chk("sync0_pulse", {sync_done0, sync_done1}, 2'b10);
        tick();
        chk("sync0_held", {sync_done0, sync_done1}, 2'b00);
        sync_req0 = 1'b0; sync_req1 = 1'b1;
        tick();
        chk("sync1_pulse", {sync_done0, sync_done1}, 2'b01);
        sync_req1 = 1'b0;
        tick();
        chk("sync_clear", {sync_done0, sync_done1}, 2'b00);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
